// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit : imem req/ack fetch front end with prefetch FIFO to decode.
// Optional macro HALT_DETECT_EN stops fetching once opcode 4'hF is buffered. Rev 1.0
// ============================================================================
module instr_fetch_unit #(
   parameter int unsigned       ADDR_W   = 8,
   parameter int unsigned       INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               dec_valid,
   input  logic               dec_ready,
   output logic [INSTR_W-1:0] dec_instr,
   output logic [3:0]         dec_opcode,
   output logic [3:0]         dec_reg_rt_id,
   output logic [ADDR_W-1:0]  dec_pc,
   output logic               halted
);
   localparam int unsigned     PTR_W    = $clog2(DEPTH);
   localparam int unsigned     CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t             state;
   logic [ADDR_W-1:0]  fetch_pc;
   logic [ADDR_W-1:0]  fetch_pc_n;
   logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
   logic [INSTR_W-1:0] fifo_instr [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr_n;
   logic [PTR_W-1:0]   rd_ptr_n;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_n;
   logic               push;
   logic               pop;
   logic               head_is_new;
   logic               halt_push;

   // Redirect flushes by collapsing the write pointer onto the read pointer.
   always_comb begin
      push     = (state == S_REQ) && imem_ack && !redirect_valid;
      pop      = dec_valid && dec_ready && !redirect_valid;
      wr_ptr_n = wr_ptr;
      rd_ptr_n = rd_ptr;
      count_n  = count;
      if (redirect_valid) begin
         wr_ptr_n = rd_ptr;
         count_n  = '0;
      end else begin
         if (push) wr_ptr_n = wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr_n = rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
         endcase
      end
      head_is_new = push && (rd_ptr_n == wr_ptr);
      fetch_pc_n  = fetch_pc;
      if (redirect_valid)
         fetch_pc_n = redirect_pc;
      else if (push)
         fetch_pc_n = fetch_pc + ADDR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         fetch_pc  <= RESET_PC;
      end else begin
         fetch_pc <= fetch_pc_n;
         case (state)
            S_IDLE: begin
               if (redirect_valid || ((count < FULL_CNT) && !halted)) begin
                  state     <= S_REQ;
                  imem_req  <= 1'b1;
                  imem_addr <= fetch_pc_n;
               end
            end
            S_REQ: begin
               if (redirect_valid && !imem_ack) begin
                  state <= S_DROP;
               end else if (redirect_valid) begin
                  imem_addr <= fetch_pc_n;
               end else if (imem_ack) begin
                  if ((count_n < FULL_CNT) && !halt_push) begin
                     imem_addr <= fetch_pc_n;
                  end else begin
                     state    <= S_IDLE;
                     imem_req <= 1'b0;
                  end
               end
            end
            S_DROP: begin
               // Old request stays on the bus untouched until its ack retires it.
               if (imem_ack) begin
                  state     <= S_REQ;
                  imem_addr <= fetch_pc_n;
               end
            end
            default: begin
               state    <= S_IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]    <= fetch_pc;
         fifo_instr[wr_ptr] <= imem_rdata;
      end
   end

   // Decode outputs load the next head; they hold their value when the FIFO empties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         dec_valid <= 1'b0;
         dec_pc    <= '0;
         dec_instr <= '0;
      end else begin
         wr_ptr    <= wr_ptr_n;
         rd_ptr    <= rd_ptr_n;
         count     <= count_n;
         dec_valid <= (count_n != '0);
         if (count_n != '0) begin
            if (head_is_new) begin
               dec_pc    <= fetch_pc;
               dec_instr <= imem_rdata;
            end else begin
               dec_pc    <= fifo_pc[rd_ptr_n];
               dec_instr <= fifo_instr[rd_ptr_n];
            end
         end
      end
   end

   assign dec_opcode    = dec_instr[INSTR_W-1 -: 4];
   assign dec_reg_rt_id = dec_instr[INSTR_W-5 -: 4];

`ifdef HALT_DETECT_EN
   localparam logic [3:0] HALT_OPCODE = 4'hF;

   assign halt_push = push && (imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         halted <= 1'b0;
      else if (redirect_valid)
         halted <= 1'b0;
      else if (halt_push)
         halted <= 1'b1;
   end
`else
   assign halt_push = 1'b0;
   assign halted    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// tb_instr_fetch_unit : memory responder + scoreboard bench for instr_fetch_unit.
module tb_instr_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_pc = '0;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [15:0] dec_instr;
   logic [3:0]  dec_opcode;
   logic [3:0]  dec_reg_rt_id;
   logic [7:0]  dec_pc;
   logic        halted;

   instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
      .dec_opcode(dec_opcode), .dec_reg_rt_id(dec_reg_rt_id), .dec_pc(dec_pc), .halted(halted)
   );

   initial forever #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          lat = 1;
   int          drop_pending = 0;
   int          first_ack_cyc = -1;
   int          pop_cnt = 0;
   bit          hold_en = 1'b0;
   bit          halt_word_en = 1'b0;
   logic [7:0]  hold_addr = '0;
   logic [7:0]  exp_addr = '0;
   logic [7:0]  last_pop_pc = '0;
   logic [7:0]  last_ack_addr = '0;
   logic [23:0] q_exp [$];

   function automatic logic [15:0] word(input logic [7:0] a);
      if (halt_word_en && a == 8'h03) return 16'hF000;
      return {4'(a % 8'd15), a[3:0] ^ 4'hA, a};
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory model: acks after `lat` waiting cycles, checks address order and bus stability.
   initial begin : responder
      int         wait_c;
      logic       prev_req;
      logic       prev_ack;
      logic [7:0] prev_addr;
      wait_c = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
      forever begin
         @(negedge clk);
         imem_ack = 1'b0;
         if (!rst_n) begin
            wait_c = 0; prev_req = 1'b0; prev_ack = 1'b0;
         end else begin
            if (prev_req && !prev_ack) begin
               total++;
               if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                  bad++;
                  $display("FAIL req_stable: req=%0b addr=%h, required req=1 addr=%h", imem_req, imem_addr, prev_addr);
               end
            end
            prev_req  = (imem_req === 1'b1);
            prev_addr = imem_addr;
            if (imem_req === 1'b1) begin
               if (wait_c >= lat && !(hold_en && imem_addr == hold_addr)) begin
                  imem_ack   = 1'b1;
                  imem_rdata = word(imem_addr);
                  wait_c     = 0;
                  if (drop_pending > 0) begin
                     drop_pending--;
                  end else begin
                     total++;
                     if (imem_addr !== exp_addr || q_exp.size() >= 2) begin
                        bad++;
                        $display("FAIL ack_addr: addr=%h buffered=%0d, required addr=%h buffered<2", imem_addr, q_exp.size(), exp_addr);
                     end
                     q_exp.push_back({exp_addr, word(exp_addr)});
                     last_ack_addr = imem_addr;
                     exp_addr      = exp_addr + 8'd1;
                     if (first_ack_cyc < 0) first_ack_cyc = cyc;
                  end
               end else begin
                  wait_c++;
               end
            end else begin
               wait_c = 0;
            end
            prev_ack = imem_ack;
         end
      end
   end

   // Scoreboard consumer: each accepted decode beat must match the oldest acked word.
   initial begin : monitor
      logic [23:0] e;
      forever begin
         @(negedge clk);
         #3;
         if (rst_n && dec_valid === 1'b1 && dec_ready && !redirect_valid) begin
            total++;
            if (q_exp.size() == 0) begin
               bad++;
               $display("FAIL dec_unexpected: pc=%h instr=%h, required no valid entry", dec_pc, dec_instr);
            end else begin
               e = q_exp.pop_front();
               if (dec_pc !== e[23:16] || dec_instr !== e[15:0] ||
                   dec_opcode !== e[15:12] || dec_reg_rt_id !== e[11:8]) begin
                  bad++;
                  $display("FAIL dec_out: pc=%h instr=%h op=%h rt=%h, required pc=%h instr=%h op=%h rt=%h",
                           dec_pc, dec_instr, dec_opcode, dec_reg_rt_id, e[23:16], e[15:0], e[15:12], e[11:8]);
               end
            end
            pop_cnt++;
            last_pop_pc = dec_pc;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      total++;
      if (imem_req !== 1'b0) begin
         bad++;
         $display("FAIL rst_req_drop: req=%0b, required 0", imem_req);
      end
      q_exp.delete();
      exp_addr = 8'h00; drop_pending = 0; first_ack_cyc = -1; pop_cnt = 0; hold_en = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic do_redirect(input logic [7:0] tgt, input bit in_flight);
      total++;
      if ((imem_req === 1'b1 && imem_ack !== 1'b1) !== in_flight) begin
         bad++;
         $display("FAIL redir_inflight: req=%0b ack=%0b, required in_flight=%0b", imem_req, imem_ack, in_flight);
      end
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      q_exp.delete();
      exp_addr     = tgt;
      drop_pending = in_flight ? 1 : 0;
      step();
      redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      total += 6;
      if (imem_req !== 1'b0)      begin bad++; $display("FAIL reset_req: got %0b, required 0", imem_req); end
      if (imem_addr !== 8'h00)    begin bad++; $display("FAIL reset_addr: got %h, required 00", imem_addr); end
      if (dec_valid !== 1'b0)     begin bad++; $display("FAIL reset_valid: got %0b, required 0", dec_valid); end
      if (dec_pc !== 8'h00)       begin bad++; $display("FAIL reset_pc: got %h, required 00", dec_pc); end
      if (dec_instr !== 16'h0000) begin bad++; $display("FAIL reset_instr: got %h, required 0000", dec_instr); end
      if (halted !== 1'b0)        begin bad++; $display("FAIL reset_halted: got %0b, required 0", halted); end
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      logic [15:0] w0;
      int i;
      w0 = word(8'h00);
      lat = 1; dec_ready = 1'b1;
      do_reset();
      for (i = 0; i < 20 && dec_valid !== 1'b1; i++) step();
      total += 2;
      if (dec_valid !== 1'b1 || dec_pc !== 8'h00 || dec_opcode !== w0[15:12]) begin
         bad++;
         $display("FAIL stream_first: valid=%0b pc=%h op=%h, required 1 00 %h", dec_valid, dec_pc, dec_opcode, w0[15:12]);
      end
      if (cyc !== first_ack_cyc + 1) begin
         bad++;
         $display("FAIL stream_latency: valid at cycle %0d, required %0d", cyc, first_ack_cyc + 1);
      end
      for (int k = 0; k < 30; k++) step();
      total++;
      if (pop_cnt < 10 || last_pop_pc !== 8'(pop_cnt - 1)) begin
         bad++;
         $display("FAIL stream_order: pops=%0d last_pc=%h, required >=10 and last_pc=%h", pop_cnt, last_pop_pc, 8'(pop_cnt - 1));
      end
   endtask

   task automatic test_backpressure();
      int i;
      lat = 1; dec_ready = 1'b0;
      do_reset();
      for (int k = 0; k < 12; k++) step();
      total++;
      if (imem_req !== 1'b0 || dec_valid !== 1'b1 || dec_pc !== 8'h00 || last_ack_addr !== 8'h01 || q_exp.size() != 2) begin
         bad++;
         $display("FAIL bp_full: req=%0b valid=%0b pc=%h last_ack=%h buffered=%0d, required 0 1 00 01 2",
                  imem_req, dec_valid, dec_pc, last_ack_addr, q_exp.size());
      end
      dec_ready = 1'b1;
      step();
      total++;
      if (dec_valid !== 1'b1 || dec_pc !== 8'h01) begin
         bad++;
         $display("FAIL bp_pop: valid=%0b pc=%h, required 1 01", dec_valid, dec_pc);
      end
      for (i = 0; i < 10 && imem_req !== 1'b1; i++) step();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h02) begin
         bad++;
         $display("FAIL bp_resume: req=%0b addr=%h, required 1 02", imem_req, imem_addr);
      end
      for (int k = 0; k < 6; k++) step();
   endtask

   task automatic test_redirect_drop();
      int i;
      lat = 1; dec_ready = 1'b1;
      do_reset();
      hold_addr = 8'h05; hold_en = 1'b1;
      for (i = 0; i < 40 && !(imem_req === 1'b1 && imem_addr === 8'h05); i++) step();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h05) begin
         bad++;
         $display("FAIL drop_reach: req=%0b addr=%h, required 1 05", imem_req, imem_addr);
      end
      do_redirect(8'h40, 1'b1);
      total++;
      if (dec_valid !== 1'b0) begin
         bad++;
         $display("FAIL drop_flush: valid=%0b, required 0", dec_valid);
      end
      for (int k = 0; k < 3; k++) begin
         total++;
         if (imem_req !== 1'b1 || imem_addr !== 8'h05) begin
            bad++;
            $display("FAIL drop_hold: req=%0b addr=%h, required 1 05", imem_req, imem_addr);
         end
         step();
      end
      hold_en = 1'b0;
      for (i = 0; i < 10 && imem_addr === 8'h05; i++) step();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h40) begin
         bad++;
         $display("FAIL drop_next: req=%0b addr=%h, required 1 40", imem_req, imem_addr);
      end
      for (i = 0; i < 20 && dec_valid !== 1'b1; i++) step();
      total++;
      if (dec_valid !== 1'b1 || dec_pc !== 8'h40) begin
         bad++;
         $display("FAIL drop_first_pc: valid=%0b pc=%h, required 1 40", dec_valid, dec_pc);
      end
      for (int k = 0; k < 6; k++) step();
   endtask

   task automatic test_redirect_ack_pop();
      int i;
      lat = 0; dec_ready = 1'b1;
      do_reset();
      for (i = 0; i < 30 && !(imem_ack === 1'b1 && dec_valid === 1'b1); i++) step();
      total++;
      if (imem_ack !== 1'b1 || dec_valid !== 1'b1) begin
         bad++;
         $display("FAIL rap_setup: ack=%0b valid=%0b, required 1 1", imem_ack, dec_valid);
      end
      do_redirect(8'h80, 1'b0);
      total++;
      if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h80) begin
         bad++;
         $display("FAIL rap_after: valid=%0b req=%0b addr=%h, required 0 1 80", dec_valid, imem_req, imem_addr);
      end
      for (i = 0; i < 10 && dec_valid !== 1'b1; i++) step();
      total++;
      if (dec_valid !== 1'b1 || dec_pc !== 8'h80) begin
         bad++;
         $display("FAIL rap_first_pc: valid=%0b pc=%h, required 1 80", dec_valid, dec_pc);
      end
      for (int k = 0; k < 6; k++) step();
   endtask

   task automatic test_wrap();
      int i;
      lat = 1; dec_ready = 1'b1;
      do_reset();
      do_redirect(8'hFE, 1'b0);
      for (i = 0; i < 20 && !(imem_req === 1'b1 && imem_addr === 8'hFF); i++) step();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 8'hFF) begin
         bad++;
         $display("FAIL wrap_ff: req=%0b addr=%h, required 1 FF", imem_req, imem_addr);
      end
      for (i = 0; i < 10 && imem_addr === 8'hFF; i++) step();
      total++;
      if (imem_addr !== 8'h00) begin
         bad++;
         $display("FAIL wrap_00: addr=%h, required 00", imem_addr);
      end
      for (int k = 0; k < 10; k++) step();
   endtask

   task automatic test_halt();
      lat = 1; dec_ready = 1'b1; halt_word_en = 1'b1;
      do_reset();
      for (int k = 0; k < 40; k++) step();
`ifdef HALT_DETECT_EN
      total++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || last_ack_addr !== 8'h03 || pop_cnt != 4 || last_pop_pc !== 8'h03) begin
         bad++;
         $display("FAIL halt_stop: halted=%0b req=%0b last_ack=%h pops=%0d last_pc=%h, required 1 0 03 4 03",
                  halted, imem_req, last_ack_addr, pop_cnt, last_pop_pc);
      end
      do_redirect(8'h10, 1'b0);
      total++;
      if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h10) begin
         bad++;
         $display("FAIL halt_redirect: halted=%0b req=%0b addr=%h, required 0 1 10", halted, imem_req, imem_addr);
      end
      for (int k = 0; k < 8; k++) step();
`else
      total++;
      if (halted !== 1'b0 || last_ack_addr < 8'h04 || pop_cnt < 5) begin
         bad++;
         $display("FAIL halt_disabled: halted=%0b last_ack=%h pops=%0d, required 0 >=04 >=5", halted, last_ack_addr, pop_cnt);
      end
`endif
      halt_word_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_drop();
      test_redirect_ack_pop();
      test_wrap();
      test_halt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
